// File: rtl/int_sched_pkg.sv
// Shared types and helpers for the interrupt scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package int_sched_pkg;

  // Default number of maskable sources; the urgent source sits just above them.
  localparam int NUM_SRC_DEF = 8;
  localparam int URGENT_BIT  = NUM_SRC_DEF;

  typedef enum logic [1:0] {
    IDLE,
    SEL,
    REQ,
    RET
  } schedState_t;

  // Successor index with wrap back to 0 after n-1.
  function automatic int unsigned wrapNext(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Purpose: pick first set request at/above a start pointer (rr) or from index 0 (fixed).
// Latency: combinational.
// Backpressure: none; result is valid whenever any request bit is set.
// Ports: reqVec (candidates), startPtr (rr start index), rrMode (1 = round-robin),
//        pickVld (any candidate), pickId (winning index).
module rr_priority_pick
  import int_sched_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] reqVec,
  input  logic [ID_W-1:0]    startPtr,
  input  logic               rrMode,
  output logic               pickVld,
  output logic [ID_W-1:0]    pickId
);

  logic [ID_W-1:0]    base;
  logic [NUM_SRC-1:0] rotated;
  logic [ID_W-1:0]    offset;

  always_comb begin
    base    = rrMode ? startPtr : '0;
    // Concatenating the vector with itself turns the rotate into a plain shift;
    // bit 0 of the result is the candidate at the start pointer.
    rotated = NUM_SRC'({reqVec, reqVec} >> base);
    pickVld = |reqVec;
    offset  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rotated[i]) offset = ID_W'(i);
    end
    // NUM_SRC is a power of two, so the ID_W-bit add wraps modulo NUM_SRC.
    pickId = base + offset;
  end

endmodule

// File: rtl/int_priority_sched.sv
// Purpose: latch interrupt events, mask/enable them, pick one winner (urgent > fixed/rr)
//          and present it to the processor over a req/ack handshake, then retire it.
// Latency: event -> Cpu_IntReq in 3 cycles; ack -> Cpu_IntReq low in 2, next req at ack+4.
// Backpressure: a granted request is held unchanged until Cpu_IntAck; new events queue as pending bits.
// Ports: Sys_Clock/Sys_Reset (sync, active-high); Src_IntReq/Src_Urgent event pulses;
//        Cfg_* mask, enable, mode and pending clear; Cpu_Int* handshake; Sts_Pending {urgent, sources}.
module int_priority_sched
  import int_sched_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_IntReq,
  input  logic               Src_Urgent,
  input  logic               Cfg_Enable,
  input  logic [NUM_SRC-1:0] Cfg_Mask,
  input  logic               Cfg_RoundRobin,
  input  logic [NUM_SRC-1:0] Cfg_PendClr,
  output logic               Cpu_IntReq,
  output logic               Cpu_IntUrgent,
  output logic [ID_W-1:0]    Cpu_IntId,
  input  logic               Cpu_IntAck,
  output logic [NUM_SRC:0]   Sts_Pending
);

  schedState_t        state;
  logic [NUM_SRC-1:0] pendSrc;
  logic               pendUrg;
  logic [ID_W-1:0]    rrPtr;
  logic [ID_W-1:0]    selId;
  logic               selUrgent;
  logic               selRr;
  logic [NUM_SRC-1:0] eligSrc;
  logic [NUM_SRC-1:0] retireClr;
  logic               retireUrg;
  logic               pickVld;
  logic [ID_W-1:0]    pickId;

  // Masked sources stay pending but are invisible to the picker.
  assign eligSrc = Cfg_Enable ? (pendSrc & ~Cfg_Mask) : '0;

  rr_priority_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) uPick (
    .reqVec   (eligSrc),
    .startPtr (rrPtr),
    .rrMode   (Cfg_RoundRobin),
    .pickVld  (pickVld),
    .pickId   (pickId)
  );

  always_comb begin
    retireClr = '0;
    if (state == RET && !selUrgent) retireClr[selId] = 1'b1;
  end

  assign retireUrg = (state == RET) && selUrgent;

  // Set wins over any clear, so an event landing on its own retire cycle is kept.
  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      pendSrc <= '0;
      pendUrg <= 1'b0;
    end else begin
      pendSrc <= Src_IntReq | (pendSrc & ~(Cfg_PendClr | retireClr));
      pendUrg <= Src_Urgent | (pendUrg & ~retireUrg);
    end
  end

  assign Sts_Pending = {pendUrg, pendSrc};

  always_ff @(posedge Sys_Clock) begin
    if (Sys_Reset) begin
      state         <= IDLE;
      Cpu_IntReq    <= 1'b0;
      Cpu_IntUrgent <= 1'b0;
      Cpu_IntId     <= '0;
      rrPtr         <= '0;
      selId         <= '0;
      selUrgent     <= 1'b0;
      selRr         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // Mode is captured with the winner so a later mode change cannot
          // affect how this grant updates the pointer.
          if (pendUrg) begin
            selUrgent <= 1'b1;
            selId     <= '0;
            selRr     <= Cfg_RoundRobin;
            state     <= SEL;
          end else if (pickVld) begin
            selUrgent <= 1'b0;
            selId     <= pickId;
            selRr     <= Cfg_RoundRobin;
            state     <= SEL;
          end
        end
        SEL: begin
          Cpu_IntReq    <= 1'b1;
          Cpu_IntUrgent <= selUrgent;
          Cpu_IntId     <= selId;
          state         <= REQ;
        end
        REQ: begin
          // No withdrawal: only the acknowledge moves us on.
          if (Cpu_IntAck) state <= RET;
        end
        RET: begin
          Cpu_IntReq <= 1'b0;
          if (selRr && !selUrgent)
            rrPtr <= ID_W'(wrapNext(32'(selId), 32'(NUM_SRC)));
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
